// File: rtl/cern_be_mux_pkg.sv
// Shared types and constants for the CERN-BE submap multiplexer.
package cern_be_mux_pkg;

   // Transaction FSM: one outstanding read or write at a time.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_WR_WAIT = 2'd2
   } mux_state_e;

   // Fill bit for read data returned on an error or timeout (all zeros).
   localparam logic ERR_RD_BIT = 1'b0;

endpackage

// File: rtl/cern_be_mux_timeout.sv
// Loadable wait-cycle counter. Cleared when a submap access is launched,
// counts every cycle spent waiting, and flags the last permitted wait cycle.
module cern_be_mux_timeout #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CNT_W-1:0] cnt;

   // Count wait cycles; a new launch restarts from zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // The wait cycle holding count TIMEOUT-1 is the TIMEOUT-th one.
   assign expired = en && (cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cern_be_submap_mux.sv
// CERN-BE master-to-submap multiplexer. Master strobes are registered once,
// decoded on the upper address bits and forwarded as a one-cycle strobe to the
// selected submap; the selected submap's ack is turned into a registered master
// done pulse. Indices beyond N_SUB complete immediately with err=1.
// Optional feature: define CERN_BE_MUX_TIMEOUT_EN to abort waits after TIMEOUT
// cycles with err=1; without it a wait lasts until the selected submap acks.
import cern_be_mux_pkg::*;

module cern_be_submap_mux #(
   parameter int N_SUB      = 4,
   parameter int ADDR_W     = 8,
   parameter int SUB_ADDR_W = 6,
   parameter int DATA_W     = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            vme_addr_i,
   input  logic [DATA_W-1:0]            vme_wr_data_i,
   input  logic                         vme_rd_mem_i,
   input  logic                         vme_wr_mem_i,
   output logic [DATA_W-1:0]            vme_rd_data_o,
   output logic                         vme_rd_done_o,
   output logic                         vme_wr_done_o,
   output logic                         vme_err_o,
   output logic [N_SUB*SUB_ADDR_W-1:0]  sub_addr_o,
   output logic [DATA_W-1:0]            sub_wr_data_o,
   output logic [N_SUB-1:0]             sub_rd_mem_o,
   output logic [N_SUB-1:0]             sub_wr_mem_o,
   input  logic [N_SUB*DATA_W-1:0]      sub_rd_data_i,
   input  logic [N_SUB-1:0]             sub_rd_done_i,
   input  logic [N_SUB-1:0]             sub_wr_done_i
);

   localparam int IDX_W = ADDR_W - SUB_ADDR_W;

   // Reject parameter sets the decoder cannot represent.
   if (N_SUB < 1 || N_SUB > 16 || TIMEOUT < 1 || SUB_ADDR_W >= ADDR_W) begin : g_bad_params
      $error("cern_be_submap_mux: illegal parameter combination");
   end

   // Input stage
   logic                  rd_q;
   logic                  wr_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;

   // Decode / selection
   logic [IDX_W-1:0]      idx;
   logic [N_SUB-1:0]      dec_oh;
   logic                  hit;
   logic [N_SUB-1:0]      sel_q;
   logic                  sel_rd_ack;
   logic                  sel_wr_ack;
   logic [DATA_W-1:0]     sel_rd_data;
   logic [SUB_ADDR_W-1:0] sub_addr_q;

   // FSM
   mux_state_e            state;
   mux_state_e            state_nxt;
   logic                  launch_rd;
   logic                  launch_wr;
   logic                  done_rd;
   logic                  done_wr;
   logic                  done_err;
   logic                  cap_data;
   logic                  timeout_hit;

   // Register master strobes, address and write data before decoding.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         rd_q    <= vme_rd_mem_i;
         wr_q    <= vme_wr_mem_i;
         addr_q  <= vme_addr_i;
         wdata_q <= vme_wr_data_i;
      end
   end

   assign idx = addr_q[ADDR_W-1:SUB_ADDR_W];

   // One-hot submap decode; an out-of-range index decodes to all zeros.
   always_comb begin
      dec_oh = '0;
      for (int k = 0; k < N_SUB; k++) begin
         dec_oh[k] = (32'(idx) == 32'(k));
      end
   end

   assign hit        = |dec_oh;
   assign sel_rd_ack = |(sub_rd_done_i & sel_q);
   assign sel_wr_ack = |(sub_wr_done_i & sel_q);

   // Pick the read data of the submap owning the current transaction.
   always_comb begin
      sel_rd_data = '0;
      for (int k = 0; k < N_SUB; k++) begin
         if (sel_q[k]) begin
            sel_rd_data = sel_rd_data | sub_rd_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

`ifdef CERN_BE_MUX_TIMEOUT_EN
   cern_be_mux_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (launch_rd | launch_wr),
      .en      (state != ST_IDLE),
      .expired (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and transaction events; write wins over a simultaneous read,
   // and strobes seen outside IDLE are dropped.
   always_comb begin
      state_nxt = state;
      launch_rd = 1'b0;
      launch_wr = 1'b0;
      done_rd   = 1'b0;
      done_wr   = 1'b0;
      done_err  = 1'b0;
      cap_data  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (wr_q) begin
               if (hit) begin
                  launch_wr = 1'b1;
                  state_nxt = ST_WR_WAIT;
               end else begin
                  done_wr  = 1'b1;
                  done_err = 1'b1;
               end
            end else if (rd_q) begin
               if (hit) begin
                  launch_rd = 1'b1;
                  state_nxt = ST_RD_WAIT;
               end else begin
                  done_rd  = 1'b1;
                  done_err = 1'b1;
               end
            end
         end
         ST_RD_WAIT: begin
            if (sel_rd_ack) begin
               done_rd   = 1'b1;
               cap_data  = 1'b1;
               state_nxt = ST_IDLE;
            end else if (timeout_hit) begin
               done_rd   = 1'b1;
               done_err  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_WR_WAIT: begin
            if (sel_wr_ack) begin
               done_wr   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (timeout_hit) begin
               done_wr   = 1'b1;
               done_err  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Registered submap strobes, held address/data and master done pulses.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sub_rd_mem_o  <= '0;
         sub_wr_mem_o  <= '0;
         sel_q         <= '0;
         sub_addr_q    <= '0;
         sub_wr_data_o <= '0;
         vme_rd_done_o <= 1'b0;
         vme_wr_done_o <= 1'b0;
         vme_err_o     <= 1'b0;
         vme_rd_data_o <= '0;
      end else begin
         sub_rd_mem_o  <= launch_rd ? dec_oh : '0;
         sub_wr_mem_o  <= launch_wr ? dec_oh : '0;
         if (launch_rd || launch_wr) begin
            sel_q      <= dec_oh;
            sub_addr_q <= addr_q[SUB_ADDR_W-1:0];
         end
         if (launch_wr) begin
            sub_wr_data_o <= wdata_q;
         end
         vme_rd_done_o <= done_rd;
         vme_wr_done_o <= done_wr;
         vme_err_o     <= done_err;
         if (done_rd) begin
            vme_rd_data_o <= cap_data ? sel_rd_data : {DATA_W{ERR_RD_BIT}};
         end
      end
   end

   assign sub_addr_o = {N_SUB{sub_addr_q}};

endmodule
